vec_store_unit: RTL and testbench
=================================

// Module: vec_store_unit
// PURPOSE
//  Store-side counterpart of the vector load path. Takes a vector register value
//  (vs3) from the vector register file and writes it to main memory, one 32-bit
//  beat at a time. Supports unit-stride and constant-stride addressing.
//  Sits between vector_processor_controller/vec_decode and the main-memory write port.
// PARAMETERS
//  XLEN      32    scalar data/address width
//  VLEN      512   bits per vector register
//  MAX_VLEN  4096  widest grouped source (LMUL=8), width of vs3_data
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous active-high reset
//  rs1_data       in   XLEN      base address
//  rs2_data       in   XLEN      byte stride (used when stride_sel=0)
//  vlmax          in   10        number of elements to store
//  sew            in   7         element width in bits: 8, 16 or 32
//  stride_sel     in   1         1 = unit stride, 0 = constant stride
//  st_inst        in   1         start pulse, sampled only in IDLE
//  vs3_data       in   MAX_VLEN  source vector data; element i = vs3_data[i*sew +: sew]
//  lsu2mem_addr   out  XLEN      word-aligned write address (addr & ~3)
//  lsu2mem_data   out  32        write data, element shifted to byte lane addr[1:0]
//  lsu2mem_wmask  out  4         byte enables
//  st_req         out  1         write request valid
//  mem2lsu_ack    in   1         memory accepts the beat on a clk edge where st_req=1
//  busy           out  1         high in STORE and DONE
//  is_stored      out  1         one-cycle pulse when the store completes
//  misalign_err   out  1         sticky until the next accepted st_inst; element crossed a word
// BEHAVIOUR
//  Reset: IDLE; st_req=0, is_stored=0, busy=0, misalign_err=0, addr/data/mask=0. All regs sync.
//  FSM: IDLE -> STORE -> DONE -> IDLE.
//  IDLE
//  - st_inst=1: latch rs1, rs2, sew, stride_sel, vs3_data, vlmax; clear idx and misalign_err.
//  - Clamp n = min(vlmax, MAX_VLEN/sew).
//  - n=0 or sew not in {8,16,32}: go directly to DONE with no beats.
//  - Otherwise go to STORE.
//  STORE
//  - byte addr a = base + idx*(sew/8) (unit) or base + idx*stride (strided); 32-bit wrap.
//  - Outputs registered: first beat's st_req rises the cycle after st_inst.
//  - addr/data/mask stay stable while st_req=1 and ack=0. ack with st_req=0 is ignored.
//  - Mask: sew8 -> 4'b0001<<a[1:0]; sew16 -> 4'b0011<<a[1:0]; sew32 -> 4'b1111. Data shifted 8*a[1:0].
//  - Element crossing a word (sew16 with a[1:0]=3; sew32 with a[1:0]!=0): no beat issued.
//    Set misalign_err, idx++ (costs one cycle).
//  - Beat accepted (st_req & ack): idx++. On the last element, drop st_req and go to DONE;
//    otherwise present the next beat the following cycle (no bubble needed).
//  DONE: is_stored=1 for exactly one cycle, then IDLE. st_inst in STORE or DONE is ignored.
//  Reset mid-operation: next cycle st_req=0, FSM IDLE, no further beats, is_stored never pulses.
// CONFIGURATION
//  VEC_ST_PACK_EN defined:
//  - unit stride and sew<32: consecutive elements in the same word merge into one beat (OR of masks).
//  - e.g. sew8 at aligned base: 4 elements/beat, mask 4'b1111.
//  - Partial first/last words carry partial masks. idx advances by the number of elements merged.
//  VEC_ST_PACK_EN undefined: always one element per beat. Strided mode never packs.
// TESTING
//  1. sew32 unit, base 0x400, vlmax 16, ack tied 1 -> 16 beats at 0x400..0x43C, mask F,
//     data = vs3 words 0..15; is_stored 1 cycle after last.
//  2. sew32 strided, base 0x400, stride 12, vlmax 16 -> addrs 0x400,0x40C,...,0x4B4; mask F.
//  3. sew8 unit, base 0x201, vlmax 4, no pack -> addr 0x200 masks 2,4,8 then 0x204 mask 1;
//     data byte in matching lane.
//  4. ack low 3 cycles on beat 2 -> addr/data/mask held unchanged; total beats still = vlmax.
//  5. rst asserted mid-store (beat 5 of 16) -> st_req=0 next cycle, no is_stored;
//     a new st_inst restarts at idx 0.
//  6. vlmax 0 -> is_stored 2 cycles after st_inst, st_req never high.
//     sew16 base 0x3 -> misalign_err=1.
//  7. VEC_ST_PACK_EN, sew8 unit, base 0x200, vlmax 64 -> 16 beats, mask F each.

Source files
------------

// File: rtl/vec_store_if.sv
// Main-memory write port of the vector store unit: one 32-bit beat per accepted request.
interface vec_store_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lsu2mem_addr;
  logic [31:0]     lsu2mem_data;
  logic [3:0]      lsu2mem_wmask;
  logic            st_req;
  logic            mem2lsu_ack;

  modport master (
    output lsu2mem_addr, lsu2mem_data, lsu2mem_wmask, st_req,
    input  mem2lsu_ack
  );

  modport slave (
    input  lsu2mem_addr, lsu2mem_data, lsu2mem_wmask, st_req,
    output mem2lsu_ack
  );
endinterface

// File: rtl/vec_store_unit.sv
// Vector store unit: writes vs3 to memory one word beat at a time, unit or constant stride.
// Optional macro VEC_ST_PACK_EN merges consecutive unit-stride sub-word elements into one beat.
module vec_store_unit #(
  parameter int XLEN     = 32,
  parameter int VLEN     = 512,
  parameter int MAX_VLEN = 8 * VLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     rs1_data_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  input  logic [9:0]          vlmax_i,
  input  logic [6:0]          sew_i,
  input  logic                stride_sel_i,
  input  logic                st_inst_i,
  input  logic [MAX_VLEN-1:0] vs3_data_i,
  vec_store_if.master         mem,
  output logic                busy_o,
  output logic                is_stored_o,
  output logic                misalign_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     base_q, base_d, stride_q, stride_d;
  logic [2:0]          bw_q, bw_d;
  logic                unit_q, unit_d;
  logic [MAX_VLEN-1:0] vs3_q, vs3_d;
  logic [9:0]          n_q, n_d, idx_q, idx_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          mask_q, mask_d;
  logic                req_q, req_d, stored_q, stored_d, err_q, err_d;
  logic                take;

  function automatic logic [2:0] sew_bytes(input logic [6:0] sew);
    case (sew)
      7'd8:    return 3'd1;
      7'd16:   return 3'd2;
      7'd32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [9:0] clamp_len(input logic [9:0] vl, input logic [2:0] bw);
    logic [9:0] cap;
    case (bw)
      3'd1:    cap = 10'(MAX_VLEN / 8);
      3'd2:    cap = 10'(MAX_VLEN / 16);
      default: cap = 10'(MAX_VLEN / 32);
    endcase
    return (vl < cap) ? vl : cap;
  endfunction

  // Beat evaluation reads the ports directly in IDLE so the first beat is ready one cycle after st_inst.
  logic                in_idle;
  logic [XLEN-1:0]     ev_base, ev_stride, ev_step, ev_addr;
  logic [2:0]          ev_bw, ev_cnt;
  logic                ev_unit, ev_mis, ev_done;
  logic [MAX_VLEN-1:0] ev_vs3;
  logic [9:0]          ev_n, ev_idx;
  logic [1:0]          ev_off;
  logic [3:0]          ev_nb, ev_mask;
  logic [12:0]         ev_sh;
  logic [31:0]         ev_word, ev_bmask, ev_data;
`ifdef VEC_ST_PACK_EN
  logic [9:0]          ev_rem;
  logic [2:0]          ev_fit;
`endif

  assign in_idle = (state_q == S_IDLE);

  always_comb begin
    ev_base   = in_idle ? rs1_data_i   : base_q;
    ev_stride = in_idle ? rs2_data_i   : stride_q;
    ev_unit   = in_idle ? stride_sel_i : unit_q;
    ev_vs3    = in_idle ? vs3_data_i   : vs3_q;
    ev_bw     = in_idle ? sew_bytes(sew_i) : bw_q;
    ev_n      = in_idle ? clamp_len(vlmax_i, ev_bw) : n_q;
    ev_idx    = in_idle ? 10'd0 : idx_q;
    ev_step   = ev_unit ? XLEN'(ev_bw) : ev_stride;
    ev_addr   = ev_base + XLEN'(ev_idx) * ev_step;
    ev_off    = ev_addr[1:0];
    ev_mis    = ((ev_bw == 3'd2) && (ev_off == 2'd3)) || ((ev_bw == 3'd4) && (ev_off != 2'd0));
    ev_done   = (ev_idx >= ev_n);
    ev_cnt    = 3'd1;
`ifdef VEC_ST_PACK_EN
    ev_rem    = ev_n - ev_idx;
    ev_fit    = 3'd0;
    if (ev_unit && ((ev_bw == 3'd1) || (ev_bw == 3'd2))) begin
      ev_fit = (3'd4 - {1'b0, ev_off}) / ev_bw;
      if (ev_fit != 3'd0) ev_cnt = (ev_rem < 10'(ev_fit)) ? ev_rem[2:0] : ev_fit;
    end
`endif
    ev_nb    = 4'(ev_cnt) * 4'(ev_bw);
    ev_sh    = 13'(ev_idx) * 13'(ev_bw) * 13'd8;
    ev_word  = 32'(ev_vs3 >> ev_sh);
    ev_bmask = (ev_nb >= 4'd4) ? 32'hFFFF_FFFF : ((32'd1 << {ev_nb, 3'b000}) - 32'd1);
    ev_data  = (ev_word & ev_bmask) << {ev_off, 3'b000};
    ev_mask  = 4'(8'((5'd1 << ev_nb) - 5'd1) << ev_off);
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    stride_d = stride_q;
    bw_d     = bw_q;
    unit_d   = unit_q;
    vs3_d    = vs3_q;
    n_d      = n_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    req_d    = req_q;
    err_d    = err_q;
    stored_d = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      S_IDLE: if (st_inst_i) begin
        base_d   = rs1_data_i;
        stride_d = rs2_data_i;
        bw_d     = ev_bw;
        unit_d   = stride_sel_i;
        vs3_d    = vs3_data_i;
        n_d      = ev_n;
        idx_d    = 10'd0;
        err_d    = 1'b0;
        if ((ev_bw == 3'd0) || (ev_n == 10'd0)) state_d = S_DONE;
        else begin
          state_d = S_STORE;
          take    = 1'b1;
        end
      end
      S_STORE: if (!req_q || mem.mem2lsu_ack) begin
        if (ev_done) begin
          req_d   = 1'b0;
          state_d = S_DONE;
        end else take = 1'b1;
      end
      S_DONE: begin
        stored_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A word-crossing element is skipped without a beat and flagged.
    if (take) begin
      if (ev_mis) begin
        err_d = 1'b1;
        idx_d = ev_idx + 10'd1;
        req_d = 1'b0;
      end else begin
        addr_d = {ev_addr[XLEN-1:2], 2'b00};
        data_d = ev_data;
        mask_d = ev_mask;
        req_d  = 1'b1;
        idx_d  = ev_idx + 10'(ev_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      req_q    <= 1'b0;
      stored_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      req_q    <= req_d;
      stored_q <= stored_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q   <= base_d;
    stride_q <= stride_d;
    bw_q     <= bw_d;
    unit_q   <= unit_d;
    vs3_q    <= vs3_d;
  end

  assign mem.lsu2mem_addr  = addr_q;
  assign mem.lsu2mem_data  = data_q;
  assign mem.lsu2mem_wmask = mask_q;
  assign mem.st_req        = req_q;
  assign busy_o            = (state_q != S_IDLE);
  assign is_stored_o       = stored_q;
  assign misalign_err_o    = err_q;

endmodule

// File: tb/tb_vec_store_unit.sv
// Scoreboard bench for vec_store_unit: byte-level reference model feeds an expected-beat queue.
`timescale 1ns/1ps
module tb_vec_store_unit;
  localparam int XLEN = 32, VLEN = 512, MAX_VLEN = 4096;
`ifdef VEC_ST_PACK_EN
  localparam bit PACK = 1'b1;
`else
  localparam bit PACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] rs1 = '0, rs2 = '0;
  logic [9:0]  vlmax = '0;
  logic [6:0]  sew = '0;
  logic        stride_sel = 1'b0, st_inst = 1'b0, ack = 1'b0;
  logic [MAX_VLEN-1:0] vs3 = '0;
  logic        busy, is_stored, mis_err;

  vec_store_if #(.XLEN(XLEN)) mif ();
  assign mif.mem2lsu_ack = ack;

  vec_store_unit #(.XLEN(XLEN), .VLEN(VLEN), .MAX_VLEN(MAX_VLEN)) dut (
    .clk(clk), .rst(rst), .rs1_data_i(rs1), .rs2_data_i(rs2), .vlmax_i(vlmax),
    .sew_i(sew), .stride_sel_i(stride_sel), .st_inst_i(st_inst), .vs3_data_i(vs3),
    .mem(mif), .busy_o(busy), .is_stored_o(is_stored), .misalign_err_o(mis_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, beats_seen = 0, stored_cnt = 0;
  int last_beat_cyc = 0, last_stored_cyc = 0;
  int ack_mode = 0, m2_base = 0, low_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: ack = 1'b1;
      1: ack = ($urandom_range(0, 3) != 0);
      default: begin
        if (mif.st_req && (beats_seen - m2_base == 1) && low_cnt < 3) begin
          ack = 1'b0;
          low_cnt++;
        end else ack = 1'b1;
      end
    endcase
  end

  // Monitor: pops an expected beat for every accepted request and checks hold stability.
  logic        hold_v = 1'b0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_mask;
  always @(negedge clk) begin
    if (rst) hold_v = 1'b0;
    else begin
      if (hold_v && mif.st_req) begin
        chk("hold_addr", mif.lsu2mem_addr, h_addr);
        chk("hold_data", mif.lsu2mem_data, h_data);
        chk("hold_mask", mif.lsu2mem_wmask, h_mask);
      end
      if (mif.st_req && ack) begin
        beats_seen++;
        last_beat_cyc = cyc;
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr %0h, required no beat", mif.lsu2mem_addr);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_addr", mif.lsu2mem_addr, e.addr);
          chk("beat_data", mif.lsu2mem_data, e.data);
          chk("beat_mask", mif.lsu2mem_wmask, e.mask);
        end
      end else if (mif.st_req) begin
        hold_v = 1'b1;
        h_addr = mif.lsu2mem_addr;
        h_data = mif.lsu2mem_data;
        h_mask = mif.lsu2mem_wmask;
      end else hold_v = 1'b0;
      if (is_stored) begin
        stored_cnt++;
        last_stored_cyc = cyc;
      end
    end
  end

  // Reference: place each element's bytes into its memory word; optionally merge same-word elements.
  task automatic model_op(input logic [31:0] base, input logic [31:0] stride, input int vl,
                          input int sw, input bit unit, input logic [MAX_VLEN-1:0] v,
                          output int nbeats, output bit err, output bit first_ok);
    int bw, n, lane;
    bit have;
    beat_t cur;
    logic [31:0] a;
    nbeats = 0; err = 1'b0; first_ok = 1'b0; have = 1'b0;
    cur.addr = '0; cur.data = '0; cur.mask = '0;
    if (!(sw == 8 || sw == 16 || sw == 32)) return;
    bw = sw / 8;
    n = (vl < MAX_VLEN / sw) ? vl : MAX_VLEN / sw;
    for (int i = 0; i < n; i++) begin
      a = unit ? base + 32'(i * bw) : base + 32'(i) * stride;
      if (int'(a[1:0]) + bw > 4) begin
        err = 1'b1;
        if (have) begin exp_q.push_back(cur); nbeats++; have = 1'b0; end
        continue;
      end
      if (i == 0) first_ok = 1'b1;
      if (!(have && PACK && unit && bw < 4 && cur.addr == {a[31:2], 2'b00})) begin
        if (have) begin exp_q.push_back(cur); nbeats++; end
        cur.addr = {a[31:2], 2'b00}; cur.data = '0; cur.mask = '0; have = 1'b1;
      end
      for (int k = 0; k < bw; k++) begin
        lane = int'(a[1:0]) + k;
        cur.data[lane*8 +: 8] = v[i*sw + k*8 +: 8];
        cur.mask[lane] = 1'b1;
      end
    end
    if (have) begin exp_q.push_back(cur); nbeats++; end
  endtask

  task automatic issue(input logic [31:0] base, input logic [31:0] stride, input int vl,
                       input int sw, input bit unit, input logic [MAX_VLEN-1:0] v);
    @(posedge clk); #2;
    rs1 = base; rs2 = stride; vlmax = 10'(vl); sew = 7'(sw); stride_sel = unit; vs3 = v;
    st_inst = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] base, input logic [31:0] stride,
                        input int vl, input int sw, input bit unit);
    int nb, s0, b0, inst_cyc;
    bit e, f, done;
    logic [MAX_VLEN-1:0] v;
    for (int w = 0; w < MAX_VLEN / 32; w++) v[w*32 +: 32] = $urandom;
    model_op(base, stride, vl, sw, unit, v, nb, e, f);
    s0 = stored_cnt; b0 = beats_seen;
    issue(base, stride, vl, sw, unit, v);
    @(negedge clk); inst_cyc = cyc;
    @(posedge clk); #2;
    st_inst = 1'b0; rs1 = $urandom; rs2 = $urandom; vs3 = ~v;
    vlmax = 10'($urandom); sew = 7'($urandom); stride_sel = ~unit;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    if (nb > 0 && f) chk({tag, "_first_req"}, mif.st_req, 1);
    done = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      if (stored_cnt != s0) begin done = 1'b1; break; end
      @(negedge clk);
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no is_stored, required one", tag);
    end
    if (nb == 0 && !e) chk({tag, "_stored_lat"}, last_stored_cyc - inst_cyc, 2);
    if (nb > 0 && !e)  chk({tag, "_stored_lat"}, last_stored_cyc - last_beat_cyc, 2);
    chk({tag, "_beats"}, beats_seen - b0, nb);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_misalign"}, mis_err, e);
    @(negedge clk);
    chk({tag, "_stored_once"}, stored_cnt - s0, 1);
    chk({tag, "_idle"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb, b0, s0, sw, r;
    bit e, f, unit;
    logic [31:0] base, stride;
    logic [MAX_VLEN-1:0] v;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_st_req", mif.st_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_is_stored", is_stored, 0);
    chk("rst_misalign", mis_err, 0);
    chk("rst_addr", mif.lsu2mem_addr, 0);
    chk("rst_data", mif.lsu2mem_data, 0);
    chk("rst_mask", mif.lsu2mem_wmask, 0);
    @(posedge clk); #2 rst = 1'b0;

    ack_mode = 0;
    run_op("t1_unit32", 32'h400, 32'h0, 16, 32, 1'b1);
    run_op("t2_stride32", 32'h400, 32'd12, 16, 32, 1'b0);
    run_op("t3_unit8_off", 32'h201, 32'h0, 4, 8, 1'b1);

    ack_mode = 2; m2_base = beats_seen; low_cnt = 0;
    run_op("t4_ack_stall", 32'h1000, 32'h0, 8, 32, 1'b1);
    chk("t4_low_cycles", low_cnt, 3);

    // Reset in the middle of a 16-beat store, then restart from element 0.
    ack_mode = 0;
    for (int w = 0; w < MAX_VLEN / 32; w++) v[w*32 +: 32] = $urandom;
    model_op(32'h400, 32'h0, 16, 32, 1'b1, v, nb, e, f);
    b0 = beats_seen; s0 = stored_cnt;
    issue(32'h400, 32'h0, 16, 32, 1'b1, v);
    @(posedge clk); #2 st_inst = 1'b0;
    for (int t = 0; t < 200 && beats_seen - b0 < 5; t++) @(negedge clk);
    chk("t5_reached_beat5", (beats_seen - b0 >= 5), 1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    b0 = beats_seen;
    @(negedge clk);
    chk("t5_req_after_rst", mif.st_req, 0);
    chk("t5_busy_after_rst", busy, 0);
    exp_q.delete();
    repeat (6) @(negedge clk);
    chk("t5_no_beats_after_rst", beats_seen - b0, 0);
    chk("t5_no_stored", stored_cnt - s0, 0);
    run_op("t5_restart", 32'h400, 32'h0, 16, 32, 1'b1);

    run_op("t6_vlmax0", 32'h80, 32'h0, 0, 32, 1'b1);
    run_op("t6_mis16", 32'h3, 32'h0, 4, 16, 1'b1);
    run_op("t6_bad_sew", 32'h40, 32'h0, 5, 24, 1'b1);
    run_op("t7_pack8", 32'h200, 32'h0, 64, 8, 1'b1);
    run_op("t7_pack16_off", 32'h302, 32'h0, 7, 16, 1'b1);
    run_op("clamp_sew32", 32'h0, 32'h0, 1000, 32, 1'b1);

    ack_mode = 1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      sw = (r < 3) ? 8 : (r < 6) ? 16 : (r < 9) ? 32 : 24;
      unit = 1'($urandom_range(0, 1));
      base = $urandom;
      if ($urandom_range(0, 1) == 0) base[1:0] = 2'b00;
      stride = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
      run_op("rand", base, stride,
             ($urandom_range(0, 8) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 24),
             sw, unit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
